// File: rtl/dest_drain_pkg.sv
// Shared types and constants for the destination-FIFO drain controller.
package dest_drain_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/drain_out_buf.sv
// Two-entry in-order {dest, data} buffer with valid/ready read side.
// Async active-low clear; occupancy exported for pop admission.
module drain_out_buf
  import dest_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic              wr_dest,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_dest,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        occ
);

  logic [DATA_W:0] mem_q [2];
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd;

  assign rd_valid = (cnt_q != 2'd0);
  assign rd       = rd_valid & rd_ready;
  assign occ      = cnt_q;
  assign {rd_dest, rd_data} = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_en) wp_d = ~wp_q;
    if (rd)    rp_d = ~rp_q;
    unique case ({wr_en, rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Write while full and reading is safe: the slot written is the head leaving.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (wr_en) mem_q[wp_q] <= {wr_dest, wr_data};
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dest_drain_ctrl.sv
// Round-robin reader for destination FIFOs D0/D1 with output buffer.
// Define DRAIN_CHECK_EN to enable the per-destination sequence checker.
module dest_drain_ctrl
  import dest_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              fifo_empty_d0,
  input  logic              fifo_empty_d1,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic              sink_ready,
  output logic              pop_d0,
  output logic              pop_d1,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dest,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              idle,
  output logic              err_seq
);

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               infl_q, infl_dest_q;
  logic [CNT_W-1:0]   cnt0_q, cnt1_q;
  logic [1:0]         occ;
  logic               xfer;
  logic               start;
  logic               has_space;
  logic [2:0]         used;
  logic [DATA_W-1:0]  wr_data;

  assign xfer      = rd_valid & sink_ready;
  assign used      = {1'b0, occ} + {2'b00, infl_q};
  assign has_space = used < (3'd2 + {2'b00, xfer});
  assign wr_data   = (infl_dest_q == DEST_D1) ? data_out_1 : data_out_0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pop_d0  = 1'b0;
    pop_d1  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (!init) begin
          state_d = DRAIN;
        end else if (has_space) begin
          if (!fifo_empty_d0 && !fifo_empty_d1) begin
            pop_d0 = (rr_q == DEST_D0);
            pop_d1 = (rr_q == DEST_D1);
            rr_d   = ~rr_q;
          end else if (!fifo_empty_d0) begin
            pop_d0 = 1'b1;
            rr_d   = DEST_D1;
          end else if (!fifo_empty_d1) begin
            pop_d1 = 1'b1;
            rr_d   = DEST_D0;
          end
        end
      end
      DRAIN: begin
        if (init) begin
          state_d = ACTIVE;
        end else if (occ == 2'd0 && !infl_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      rr_q        <= DEST_D0;
      infl_q      <= 1'b0;
      infl_dest_q <= DEST_D0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      infl_q      <= pop_d0 | pop_d1;
      infl_dest_q <= pop_d1 ? DEST_D1 : DEST_D0;
    end
  end

  // Delivered-word counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (start) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (xfer) begin
      if (rd_dest == DEST_D0 && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
      if (rd_dest == DEST_D1 && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  drain_out_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk      (clk),
    .reset_L  (reset_L),
    .wr_en    (infl_q),
    .wr_dest  (infl_dest_q),
    .wr_data  (wr_data),
    .rd_ready (sink_ready),
    .rd_valid (rd_valid),
    .rd_dest  (rd_dest),
    .rd_data  (rd_data),
    .occ      (occ)
  );

  assign cnt_d0 = cnt0_q;
  assign cnt_d1 = cnt1_q;
  assign idle   = (state_q == IDLE);

`ifdef DRAIN_CHECK_EN
  logic [1:0]        exp_vld_q;
  logic [DATA_W-1:0] exp0_q, exp1_q;
  logic              err_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      exp_vld_q <= 2'b00;
      exp0_q    <= '0;
      exp1_q    <= '0;
      err_q     <= 1'b0;
    end else if (start) begin
      exp_vld_q <= 2'b00;
      err_q     <= 1'b0;
    end else if (xfer) begin
      if (rd_dest == DEST_D0) begin
        if (exp_vld_q[0] && rd_data != exp0_q) err_q <= 1'b1;
        exp0_q       <= rd_data + 1'b1;
        exp_vld_q[0] <= 1'b1;
      end else begin
        if (exp_vld_q[1] && rd_data != exp1_q) err_q <= 1'b1;
        exp1_q       <= rd_data + 1'b1;
        exp_vld_q[1] <= 1'b1;
      end
    end
  end

  assign err_seq = err_q;
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_dest_drain_ctrl.sv
// Bench for dest_drain_ctrl: vector table, directed corners, random run.
module tb_dest_drain_ctrl;
  import dest_drain_pkg::*;

  localparam int DW = 6;
  localparam int CW = 8;
`ifdef DRAIN_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_L, init, sink_ready, fclr;
  logic [DW-1:0] data_out_0, data_out_1;
  logic          fifo_empty_d0, fifo_empty_d1;
  logic          pop_d0, pop_d1, rd_valid, rd_dest, idle, err_seq;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] cnt_d0, cnt_d1;

  always #5 clk = ~clk;

  dest_drain_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .init          (init),
    .fifo_empty_d0 (fifo_empty_d0),
    .fifo_empty_d1 (fifo_empty_d1),
    .data_out_0    (data_out_0),
    .data_out_1    (data_out_1),
    .sink_ready    (sink_ready),
    .pop_d0        (pop_d0),
    .pop_d1        (pop_d1),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_dest       (rd_dest),
    .cnt_d0        (cnt_d0),
    .cnt_d1        (cnt_d1),
    .idle          (idle),
    .err_seq       (err_seq)
  );

  // Source FIFO models: read data appears the cycle after the pop.
  logic [DW-1:0] m0 [512];
  logic [DW-1:0] m1 [512];
  int len0 = 0, len1 = 0;
  int r0 = 0, r1 = 0;

  assign fifo_empty_d0 = (r0 >= len0);
  assign fifo_empty_d1 = (r1 >= len1);

  always @(posedge clk) begin
    if (fclr) begin
      r0 <= 0;
      r1 <= 0;
      data_out_0 <= '0;
      data_out_1 <= '0;
    end else begin
      if (pop_d0 && r0 < len0) begin
        data_out_0 <= m0[r0[8:0]];
        r0 <= r0 + 1;
      end
      if (pop_d1 && r1 < len1) begin
        data_out_1 <= m1[r1[8:0]];
        r1 <= r1 + 1;
      end
    end
  end

  typedef struct packed {
    logic [3:0]      n0;
    logic [3:0]      n1;
    logic [3:0][5:0] d0;
    logic [3:0][5:0] d1;
    logic [3:0]      ne;
    logic [7:0][6:0] ex;
    logic [7:0]      c0;
    logic [7:0]      c1;
  } vec_t;

  vec_t tv [5];

  int n_cmp = 0, n_bad = 0;
  int cycn = 0;
  int npop0 = 0, npop1 = 0;
  logic [6:0] cap[$];
  int pop0_cyc[$];
  int val_cyc[$];
  logic pv = 1'b0;
  logic [6:0] pword = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cycn++;
    if (pop_d0 || pop_d1) chk("single_pop", {31'd0, pop_d0 & pop_d1}, 0);
    if (pop_d0) begin
      chk("pop0_nonempty", {31'd0, fifo_empty_d0}, 0);
      npop0++;
      pop0_cyc.push_back(cycn);
    end
    if (pop_d1) begin
      chk("pop1_nonempty", {31'd0, fifo_empty_d1}, 0);
      npop1++;
    end
    if (pv) begin
      chk("hold_valid", {31'd0, rd_valid}, 1);
      chk("hold_word", {25'd0, rd_dest, rd_data}, {25'd0, pword});
    end
    if (rd_valid) val_cyc.push_back(cycn);
    if (rd_valid && sink_ready) cap.push_back({rd_dest, rd_data});
    pv    = rd_valid && !sink_ready;
    pword = {rd_dest, rd_data};
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cap.delete();
    pop0_cyc.delete();
    val_cyc.delete();
    npop0 = 0;
    npop1 = 0;
  endtask

  task automatic do_reset();
    reset_L    = 1'b0;
    init       = 1'b0;
    sink_ready = 1'b0;
    fclr       = 1'b1;
    len0       = 0;
    len1       = 0;
    pv         = 1'b0;
    cyc();
    cyc();
    reset_L = 1'b1;
    fclr    = 1'b0;
    cyc();
  endtask

  task automatic wait_words(input int n, input int budget, input string nm);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      cyc();
      k++;
    end
    if (cap.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got %0d words need %0d", nm, cap.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (!idle && k < budget) begin
      cyc();
      k++;
    end
    chk(nm, {31'd0, idle}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] g0[$];
    logic [6:0] g1[$];
    int budget;

    tv[0].n0 = 4'd3; tv[0].n1 = 4'd0;
    tv[0].d0 = {6'h00, 6'h2F, 6'h2E, 6'h2D}; tv[0].d1 = '0;
    tv[0].ne = 4'd3; tv[0].c0 = 8'd3; tv[0].c1 = 8'd0;
    tv[0].ex = {28'h0, 7'h00, 7'h2F, 7'h2E, 7'h2D};

    tv[1].n0 = 4'd2; tv[1].n1 = 4'd2;
    tv[1].d0 = {12'h0, 6'h02, 6'h01}; tv[1].d1 = {12'h0, 6'h12, 6'h11};
    tv[1].ne = 4'd4; tv[1].c0 = 8'd2; tv[1].c1 = 8'd2;
    tv[1].ex = {28'h0, 7'h52, 7'h02, 7'h51, 7'h01};

    tv[2].n0 = 4'd0; tv[2].n1 = 4'd2;
    tv[2].d0 = '0; tv[2].d1 = {12'h0, 6'h34, 6'h33};
    tv[2].ne = 4'd2; tv[2].c0 = 8'd0; tv[2].c1 = 8'd2;
    tv[2].ex = {28'h0, 7'h00, 7'h00, 7'h74, 7'h73};

    tv[3].n0 = 4'd1; tv[3].n1 = 4'd3;
    tv[3].d0 = {18'h0, 6'h0A}; tv[3].d1 = {6'h0, 6'h1C, 6'h1B, 6'h1A};
    tv[3].ne = 4'd4; tv[3].c0 = 8'd1; tv[3].c1 = 8'd3;
    tv[3].ex = {28'h0, 7'h5C, 7'h5B, 7'h5A, 7'h0A};

    tv[4].n0 = 4'd3; tv[4].n1 = 4'd1;
    tv[4].d0 = {6'h0, 6'h07, 6'h06, 6'h05}; tv[4].d1 = {18'h0, 6'h20};
    tv[4].ne = 4'd4; tv[4].c0 = 8'd3; tv[4].c1 = 8'd1;
    tv[4].ex = {28'h0, 7'h07, 7'h06, 7'h60, 7'h05};

    // Reset state held.
    reset_L = 1'b0; init = 1'b0; sink_ready = 1'b0; fclr = 1'b1;
    cyc();
    cyc();
    chk("rst_pop0", {31'd0, pop_d0}, 0);
    chk("rst_pop1", {31'd0, pop_d1}, 0);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", {26'd0, rd_data}, 0);
    chk("rst_dest", {31'd0, rd_dest}, 0);
    chk("rst_cnt0", {24'd0, cnt_d0}, 0);
    chk("rst_cnt1", {24'd0, cnt_d1}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_err", {31'd0, err_seq}, 0);

    // Vector table, sink always ready.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int k = 0; k < int'(tv[i].n0); k++) m0[k] = tv[i].d0[k];
      for (int k = 0; k < int'(tv[i].n1); k++) m1[k] = tv[i].d1[k];
      len0 = int'(tv[i].n0);
      len1 = int'(tv[i].n1);
      clear_logs();
      init = 1'b1;
      sink_ready = 1'b1;
      wait_words(int'(tv[i].ne), 40, $sformatf("tv%0d", i));
      repeat (3) cyc();
      chk($sformatf("tv%0d_count", i), cap.size(), tv[i].ne);
      for (int j = 0; j < int'(tv[i].ne); j++)
        chk($sformatf("tv%0d_w%0d", i, j), {25'd0, cap[j]}, {25'd0, tv[i].ex[j]});
      chk($sformatf("tv%0d_cnt0", i), {24'd0, cnt_d0}, {24'd0, tv[i].c0});
      chk($sformatf("tv%0d_cnt1", i), {24'd0, cnt_d1}, {24'd0, tv[i].c1});
      chk($sformatf("tv%0d_err", i), {31'd0, err_seq}, 0);
      if (i == 0) begin
        chk("lat_npop", pop0_cyc.size(), 3);
        chk("lat_pop1", pop0_cyc[1], pop0_cyc[0] + 1);
        chk("lat_pop2", pop0_cyc[2], pop0_cyc[0] + 2);
        chk("lat_nval", val_cyc.size(), 3);
        chk("lat_first_valid", val_cyc[0], pop0_cyc[0] + 2);
        chk("lat_last_valid", val_cyc[2], pop0_cyc[0] + 4);
      end
    end

    // Backpressure: five words, sink stalled.
    do_reset();
    for (int k = 0; k < 5; k++) m0[k] = 6'h30 + 6'(k);
    len0 = 5;
    clear_logs();
    init = 1'b1;
    sink_ready = 1'b0;
    repeat (8) cyc();
    chk("stall_npop", npop0, 2);
    chk("stall_pop_low", {31'd0, pop_d0}, 0);
    chk("stall_valid", {31'd0, rd_valid}, 1);
    chk("stall_head", {25'd0, rd_dest, rd_data}, 32'h30);
    sink_ready = 1'b1;
    wait_words(5, 30, "stall_resume");
    repeat (3) cyc();
    chk("stall_count", cap.size(), 5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("stall_w%0d", j), {25'd0, cap[j]}, 32'h30 + j);
    chk("stall_cnt0", {24'd0, cnt_d0}, 5);
    chk("stall_total_pops", npop0, 5);

    // Drop init with one word buffered and one in flight.
    do_reset();
    for (int k = 0; k < 4; k++) m0[k] = 6'h20 + 6'(k);
    len0 = 4;
    clear_logs();
    init = 1'b1;
    sink_ready = 1'b0;
    repeat (3) cyc();
    init = 1'b0;
    cyc();
    chk("drain_npop_at_drop", npop0, 2);
    sink_ready = 1'b1;
    wait_idle(20, "drain_idle");
    repeat (2) cyc();
    chk("drain_count", cap.size(), 2);
    chk("drain_w0", {25'd0, cap[0]}, 32'h20);
    chk("drain_w1", {25'd0, cap[1]}, 32'h21);
    chk("drain_npop", npop0, 2);
    chk("drain_cnt0_kept", {24'd0, cnt_d0}, 2);
    init = 1'b1;
    cyc();
    chk("drain_cnt0_cleared", {24'd0, cnt_d0}, 0);

    // Reset asserted with two words buffered.
    do_reset();
    for (int k = 0; k < 6; k++) m0[k] = 6'h10 + 6'(k);
    len0 = 6;
    clear_logs();
    init = 1'b1;
    sink_ready = 1'b1;
    repeat (4) cyc();
    sink_ready = 1'b0;
    repeat (4) cyc();
    chk("mid_cnt0", {24'd0, cnt_d0}, 1);
    chk("mid_valid", {31'd0, rd_valid}, 1);
    chk("mid_head", {26'd0, rd_data}, 32'h11);
    #2 reset_L = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rd_valid}, 0);
    chk("mid_rst_cnt0", {24'd0, cnt_d0}, 0);
    chk("mid_rst_idle", {31'd0, idle}, 1);
    chk("mid_rst_pop", {30'd0, pop_d0, pop_d1}, 0);
    chk("mid_rst_data", {26'd0, rd_data}, 0);

    // Sequence checker: gap after 06.
    do_reset();
    m0[0] = 6'h05; m0[1] = 6'h06; m0[2] = 6'h08;
    len0 = 3;
    clear_logs();
    init = 1'b1;
    sink_ready = 1'b1;
    wait_words(2, 20, "seq_two");
    chk("seq_err_before", {31'd0, err_seq}, 0);
    wait_words(3, 20, "seq_three");
    chk("seq_err_after", {31'd0, err_seq}, {31'd0, ERR_EXP});
    repeat (3) cyc();
    chk("seq_err_sticky", {31'd0, err_seq}, {31'd0, ERR_EXP});

    // Counter saturation.
    do_reset();
    for (int k = 0; k < 260; k++) m0[k] = 6'(k);
    len0 = 260;
    clear_logs();
    init = 1'b1;
    sink_ready = 1'b1;
    wait_words(260, 320, "sat");
    chk("sat_cnt0", {24'd0, cnt_d0}, 255);
    chk("sat_cnt1", {24'd0, cnt_d1}, 0);

    // Random traffic against the in-order, no-loss reference.
    for (int it = 0; it < 12; it++) begin
      do_reset();
      len0 = 0;
      len1 = 0;
      for (int k = 0; k < 14; k++) begin
        m0[k] = 6'($urandom);
        m1[k] = 6'($urandom);
      end
      len0 = int'($urandom_range(0, 12));
      len1 = int'($urandom_range(0, 12));
      clear_logs();
      init = 1'b1;
      budget = 0;
      while (cap.size() < len0 + len1 && budget < 300) begin
        sink_ready = ($urandom_range(0, 3) != 0);
        cyc();
        budget++;
      end
      if (cap.size() < len0 + len1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rnd%0d timeout: got %0d words need %0d",
                 it, cap.size(), len0 + len1);
      end
      g0.delete();
      g1.delete();
      foreach (cap[j]) begin
        if (cap[j][6]) g1.push_back(cap[j]);
        else           g0.push_back(cap[j]);
      end
      chk($sformatf("rnd%0d_n0", it), g0.size(), len0);
      chk($sformatf("rnd%0d_n1", it), g1.size(), len1);
      for (int j = 0; j < len0; j++)
        chk($sformatf("rnd%0d_d0_%0d", it, j), {26'd0, g0[j][5:0]}, {26'd0, m0[j]});
      for (int j = 0; j < len1; j++)
        chk($sformatf("rnd%0d_d1_%0d", it, j), {26'd0, g1[j][5:0]}, {26'd0, m1[j]});
      chk($sformatf("rnd%0d_cnt0", it), {24'd0, cnt_d0}, len0);
      chk($sformatf("rnd%0d_cnt1", it), {24'd0, cnt_d1}, len1);
      init = 1'b0;
      sink_ready = 1'b1;
      wait_idle(20, $sformatf("rnd%0d_idle", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
